// File: rtl/gin_pkg.sv
// Shared types for the GIN tag issuer: FSM state encoding and tagged-word layout.
// Default tag/payload widths come from XID_BITS / YID_BITS / DATA_BITS unless predefined.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

package gin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gin_issuer_state_e;

  typedef struct packed {
    logic [`YID_BITS-1:0]  ytag;
    logic [`XID_BITS-1:0]  xtag;
    logic [`DATA_BITS-1:0] data;
  } gin_tagged_word_t;

endpackage

// File: rtl/gin_sync_fifo.sv
// Synchronous FIFO, flop storage read at the head pointer; push visible one cycle later.
// Push ignored when full, pop ignored when empty; count exposed for drain detection.
module gin_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gin_tag_issuer.sv
// Stamps raster-order (row, col) tags on input words and queues them for the GIN bus; one-cycle in->out latency.
// in_ready drops when the FIFO is full or outside RUN; stall_cnt exists only with GIN_TAG_ISSUER_STATS_EN.
module gin_tag_issuer
  import gin_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int XID_SIZE = `XID_BITS,
  parameter int YID_SIZE = `YID_BITS,
  parameter int DATA_W   = `DATA_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [YID_SIZE-1:0] cfg_row_base,
  input  logic [YID_SIZE-1:0] cfg_row_cnt,
  input  logic [XID_SIZE-1:0] cfg_col_base,
  input  logic [XID_SIZE-1:0] cfg_col_cnt,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [YID_SIZE-1:0] out_tag_y,
  output logic [XID_SIZE-1:0] out_tag_x,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                done
`ifdef GIN_TAG_ISSUER_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int TW = YID_SIZE + XID_SIZE + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  gin_issuer_state_e state, state_nxt;

  logic [YID_SIZE-1:0] row_base, row_cnt, row_idx;
  logic [XID_SIZE-1:0] col_base, col_cnt, col_idx;
  logic                cfg_take, accept, pop, last_elem, col_last;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [TW-1:0]       push_word, head_word;

  assign cfg_ready = (state == ST_IDLE);
  assign cfg_take  = cfg_valid && cfg_ready;
  assign in_ready  = (state == ST_RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign done      = (state == ST_DONE);
  assign col_last  = (col_idx == col_cnt - 1'b1);
  assign last_elem = col_last && (row_idx == row_cnt - 1'b1);

  // Tag sums truncate to the field width, so base+idx wraps modulo 2^width.
  assign push_word = {row_base + row_idx, col_base + col_idx, in_data};
  assign {out_tag_y, out_tag_x, out_data} = head_word;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_take)
          state_nxt = (cfg_row_cnt == '0 || cfg_col_cnt == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (accept && last_elem) state_nxt = ST_DRAIN;
      // Leave as the final word is popped so done lands the cycle after the last pop.
      ST_DRAIN: if (fifo_empty || (pop && fifo_count == CW'(1))) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_base <= '0;
      row_cnt  <= '0;
      row_idx  <= '0;
      col_base <= '0;
      col_cnt  <= '0;
      col_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_take) begin
        row_base <= cfg_row_base;
        row_cnt  <= cfg_row_cnt;
        col_base <= cfg_col_base;
        col_cnt  <= cfg_col_cnt;
        row_idx  <= '0;
        col_idx  <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_idx <= '0;
          row_idx <= row_idx + 1'b1;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end
    end
  end

  gin_sync_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (push_word),
    .pop      (pop),
    .head_dat (head_word),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef GIN_TAG_ISSUER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_take)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_gin_tag_issuer.sv
// Directed bench for gin_tag_issuer: raster tags, backpressure, wrap, zero count, mid-transfer reset, stats.
module tb_gin_tag_issuer;
  import gin_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_row_base, cfg_row_cnt, cfg_col_base, cfg_col_cnt;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready, done;
  logic [3:0]  out_tag_y, out_tag_x;
  logic [15:0] out_data;
`ifdef GIN_TAG_ISSUER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int nchk = 0;
  int nfail = 0;

  logic [3:0]  cap_y[$];
  logic [3:0]  cap_x[$];
  logic [15:0] cap_d[$];
  int          last_pop, done_cyc;

  always #5 clk = ~clk;

  gin_tag_issuer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_row_base (cfg_row_base),
    .cfg_row_cnt  (cfg_row_cnt),
    .cfg_col_base (cfg_col_base),
    .cfg_col_cnt  (cfg_col_cnt),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_tag_y    (out_tag_y),
    .out_tag_x    (out_tag_x),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .done         (done)
`ifdef GIN_TAG_ISSUER_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [3:0] rb, input logic [3:0] rc,
                        input logic [3:0] cb, input logic [3:0] cc);
    cfg_row_base = rb; cfg_row_cnt = rc; cfg_col_base = cb; cfg_col_cnt = cc;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Feeds n words with out_ready held high and captures every pop until done is seen.
  task automatic stream(input int n, input logic [15:0] dbase);
    int sent = 0;
    cap_y.delete(); cap_x.delete(); cap_d.delete();
    last_pop = -1; done_cyc = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      in_valid = (sent < n);
      in_data  = dbase + 16'(sent);
      if (done) done_cyc = c;
      if (out_valid && out_ready) begin
        cap_y.push_back(out_tag_y); cap_x.push_back(out_tag_x); cap_d.push_back(out_data);
        last_pop = c;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    nchk++; if (cfg_ready !== 1'b1) begin nfail++; $display("FAIL reset cfg_ready got %b want 1", cfg_ready); end
    nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    nchk++; if ({out_tag_y, out_tag_x, out_data} !== 24'h0) begin nfail++; $display("FAIL reset out_fields got %h want 0", {out_tag_y, out_tag_x, out_data}); end
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL reset done got %b want 0", done); end
`ifdef GIN_TAG_ISSUER_STATS_EN
    nchk++; if (stall_cnt !== 16'h0) begin nfail++; $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_raster();
    do_cfg(4'd2, 4'd2, 4'd5, 4'd3);
    stream(6, 16'hA000);
    nchk++; if (cap_y.size() != 6) begin nfail++; $display("FAIL raster pop_count got %0d want 6", cap_y.size()); end
    for (int g = 0; g < 6 && g < cap_y.size(); g++) begin
      logic [3:0] ey, ex;
      ey = 4'(2 + g / 3);
      ex = 4'(5 + g % 3);
      nchk++;
      if (cap_y[g] !== ey || cap_x[g] !== ex || cap_d[g] !== 16'hA000 + 16'(g)) begin
        nfail++;
        $display("FAIL raster word%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", g, cap_y[g], cap_x[g], cap_d[g], ey, ex, 16'hA000 + 16'(g));
      end
    end
    nchk++; if (done_cyc < 0 || done_cyc != last_pop + 1) begin nfail++; $display("FAIL raster done_timing got cycle %0d want %0d", done_cyc, last_pop + 1); end
    nchk++; if (done !== 1'b0 || cfg_ready !== 1'b1) begin nfail++; $display("FAIL raster post_done got done=%b cfg_ready=%b want 0,1", done, cfg_ready); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int npop = 0;
    int bubbles = 0;
    bit seen_done = 0;
    do_cfg(4'd0, 4'd1, 4'd0, 4'd8);
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 16'hB000 + 16'(acc);
      if (in_ready) acc++;
      step();
    end
    nchk++; if (acc != 4) begin nfail++; $display("FAIL bp accepts got %0d want 4", acc); end
    nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp in_ready_full got %b want 0", in_ready); end
    nchk++; if (out_valid !== 1'b1 || out_data !== 16'hB000) begin nfail++; $display("FAIL bp head_hold got v=%b d=%h want 1,b000", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      in_valid = (acc < 8);
      in_data  = 16'hB000 + 16'(acc);
      if (done) seen_done = 1;
      if (out_valid) begin
        nchk++;
        if (out_data !== 16'hB000 + 16'(npop) || out_tag_x !== 4'(npop) || out_tag_y !== 4'd0) begin
          nfail++;
          $display("FAIL bp order%0d got (%0d,%0d,%h) want (0,%0d,%h)", npop, out_tag_y, out_tag_x, out_data, npop, 16'hB000 + 16'(npop));
        end
        npop++;
      end else if (npop > 0 && npop < 8) begin
        bubbles++;
      end
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    nchk++; if (npop != 8) begin nfail++; $display("FAIL bp pops got %0d want 8", npop); end
    nchk++; if (bubbles != 0) begin nfail++; $display("FAIL bp throughput got %0d bubbles want 0", bubbles); end
    nchk++; if (!seen_done) begin nfail++; $display("FAIL bp done got none want pulse"); end
  endtask

  task automatic test_wrap();
    do_cfg(4'd0, 4'd1, 4'd15, 4'd2);
    stream(2, 16'hC000);
    nchk++;
    if (cap_x.size() != 2 || cap_x[0] !== 4'd15 || cap_x[1] !== 4'd0 || cap_y[0] !== 4'd0 || cap_y[1] !== 4'd0) begin
      nfail++;
      $display("FAIL wrap xtags got n=%0d x0=%0d x1=%0d want 15,0", cap_x.size(),
               cap_x.size() > 0 ? cap_x[0] : 4'hx, cap_x.size() > 1 ? cap_x[1] : 4'hx);
    end
  endtask

  task automatic test_zero_count();
    do_cfg(4'd3, 4'd0, 4'd1, 4'd3);
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL zero done got %b want 1", done); end
    nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL zero in_ready_a got %b want 0", in_ready); end
    step();
    nchk++; if (done !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b0) begin nfail++; $display("FAIL zero after got done=%b cfg_ready=%b in_ready=%b want 0,1,0", done, cfg_ready, in_ready); end
    do_cfg(4'd1, 4'd1, 4'd1, 4'd2);
    nchk++; if (cfg_ready !== 1'b0) begin nfail++; $display("FAIL ignore cfg_ready got %b want 0", cfg_ready); end
    cfg_row_base = 4'd9; cfg_row_cnt = 4'd3; cfg_col_base = 4'd7; cfg_col_cnt = 4'd4;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    stream(2, 16'hD000);
    nchk++;
    if (cap_x.size() != 2 || cap_y[0] !== 4'd1 || cap_x[0] !== 4'd1 || cap_y[1] !== 4'd1 || cap_x[1] !== 4'd2 || done_cyc < 0) begin
      nfail++;
      $display("FAIL ignore tags got n=%0d done_cyc=%0d want (1,1),(1,2) then done", cap_x.size(), done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bit saw_done = 0;
    do_cfg(4'd2, 4'd2, 4'd5, 4'd3);
    out_ready = 1'b0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 16'hF000 + 16'(acc);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    nchk++; if (acc != 3 || out_valid !== 1'b1) begin nfail++; $display("FAIL rstmid pre got acc=%0d out_valid=%b want 3,1", acc, out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nchk++; if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b0) begin nfail++; $display("FAIL rstmid state got out_valid=%b cfg_ready=%b in_ready=%b want 0,1,0", out_valid, cfg_ready, in_ready); end
    for (int c = 0; c < 4; c++) begin
      if (done) saw_done = 1;
      step();
    end
    nchk++; if (saw_done || done) begin nfail++; $display("FAIL rstmid done got pulse want none"); end
  endtask

`ifdef GIN_TAG_ISSUER_STATS_EN
  task automatic test_stats();
    int w = 0;
    do_cfg(4'd0, 4'd1, 4'd0, 4'd1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hE000;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) step();
    nchk++; if (out_valid !== 1'b1 || stall_cnt !== 16'd7) begin nfail++; $display("FAIL stats count got v=%b stall=%0d want 1,7", out_valid, stall_cnt); end
    out_ready = 1'b1;
    while (!cfg_ready && w < 20) begin step(); w++; end
    nchk++; if (!cfg_ready) begin nfail++; $display("FAIL stats idle got cfg_ready=0 want 1"); end
    do_cfg(4'd0, 4'd1, 4'd0, 4'd1);
    nchk++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL stats clear got %0d want 0", stall_cnt); end
    stream(1, 16'hE100);
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_row_base = '0; cfg_row_cnt = '0;
    cfg_col_base = '0; cfg_col_cnt = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_raster();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_reset_mid();
`ifdef GIN_TAG_ISSUER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gin_tag_issuer.md
# gin_tag_issuer

Upstream feeder for the global input network buses. It accepts a raw data stream from the global buffer and stamps each word with a (row, column) multicast tag pair generated by raster-order counters. Tagged words are buffered in a small FIFO and presented to the Y-bus / X-bus master port with a valid/ready handshake. It reports completion of each configured transfer.

## Interface

Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- XID_SIZE, `XID_BITS`: column tag width.
- YID_SIZE, `YID_BITS`: row tag width.
- DATA_W, `DATA_BITS`: payload width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_valid  in  1  load a new transfer descriptor.
- cfg_ready  out  1  high only in IDLE.
- cfg_row_base  in  YID_SIZE  first row tag.
- cfg_row_cnt  in  YID_SIZE  number of row tags.
- cfg_col_base  in  XID_SIZE  first column tag.
- cfg_col_cnt  in  XID_SIZE  number of column tags.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  word accepted when in_valid & in_ready.
- out_valid  out  1  tagged word available (drives bus master_valid).
- out_tag_y  out  YID_SIZE  row tag.
- out_tag_x  out  XID_SIZE  column tag (drives bus tag).
- out_data  out  DATA_W  payload (drives bus master_data).
- out_ready  in  1  bus master_ready.
- done  out  1  one-cycle pulse at transfer completion.
- stall_cnt  out  16  only with GIN_TAG_ISSUER_STATS_EN.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_ready=1, in_ready=0. cfg_valid latches descriptor, zeroes row_idx/col_idx → RUN. If either count is 0 → DONE directly.
- RUN: in_ready = !fifo_full. On accept, push {row_base+row_idx, col_base+col_idx, in_data}.
  - col_idx increments. At col_cnt-1 it wraps to 0 and row_idx increments.
  - Accept of last element (row_idx=row_cnt-1, col_idx=col_cnt-1) → DRAIN.
- DRAIN: in_ready=0. Waits until FIFO empty and no pop pending → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Tag arithmetic: base+idx modulo 2^width. Wrap-around is legal and not flagged.
- Pop when out_valid & out_ready. out_* fields equal the FIFO head. Head is held stable while out_valid & !out_ready.
- cfg_valid outside IDLE is ignored and not latched.

## Timing

- Reset values: state=IDLE, FIFO empty, cfg_ready=1, in_ready=0, out_valid=0, out_tag_y=0, out_tag_x=0, out_data=0, done=0, stall_cnt=0.
- cfg accepted in cycle N: in_ready may be 1 in cycle N+1.
- Word accepted in cycle N into an empty FIFO: out_valid=1 in cycle N+1. Latency is one cycle; there is no combinational in→out path.
- Full FIFO: in_ready=0, even if a pop occurs in the same cycle.
- Empty FIFO with simultaneous push/pop: not possible, since out_valid=0.
- Push and pop in the same cycle with FIFO neither full nor empty: occupancy unchanged.
- Sustained throughput: 1 word/cycle when out_ready stays high.
- Last pop in cycle N: DRAIN→DONE at N+1, done high in N+1, IDLE at N+2.
- Zero-count descriptor accepted in cycle N: done in N+1.
- rst mid-transfer: FIFO flushed, counters cleared, IDLE next cycle. No done pulse.

## Configuration

- GIN_TAG_ISSUER_STATS_EN defined:
  - stall_cnt counts cycles with out_valid & !out_ready, saturating at 0xFFFF.
  - Cleared on rst and on cfg acceptance.
- Undefined: stall_cnt port and counter logic are absent.

## Structure

- gin_pkg: state enum gin_issuer_state_e; packed struct gin_tagged_word_t {ytag, xtag, data}.
- Sub-module gin_sync_fifo:
  - Parameterized by width and DEPTH.
  - Registered output, full/empty flags.
  - Pointers with an extra wrap bit.
- Top holds the FSM, tag counters and optional stats.

## Test plan

- Config row_base=2, row_cnt=2, col_base=5, col_cnt=3; 6 words, out_ready=1 → tags (2,5),(2,6),(2,7),(3,5),(3,6),(3,7) in order; done one cycle after last pop.
- DEPTH=4, out_ready=0, in_valid=1 → exactly 4 accepts, then in_ready=0. Raise out_ready → 1 word/cycle, data order preserved.
- col_base=2^XID_SIZE-1, col_cnt=2 → x tags max, then 0.
- cfg_row_cnt=0 → done pulse next cycle, in_ready never asserted. cfg_valid during RUN → ignored.
- Assert rst after 3 of 6 words → next cycle out_valid=0, cfg_ready=1, no done pulse.
- With GIN_TAG_ISSUER_STATS_EN: 7 backpressure cycles with out_valid=1 → stall_cnt=7; new cfg clears it to 0.
